// File: rtl/wb_mux_stage.sv
// Writeback stage: selects one of NSRC result sources, aligns and extends raw
// load data, and holds the result in a stall/flush-aware pipeline register.
module wb_mux_stage #(
  parameter int XLEN    = 32,
  parameter int NSRC    = 4,
  parameter int MEM_SEL = 1,
  localparam int SELW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]      sel,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [4:0]           rd_in,
  input  logic                 reg_write,
  output logic                 in_ready,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_we,
  output logic                 load_err,
  output logic [31:0]          wr_count
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  logic [XLEN-1:0] w_src [NSRC];
  logic [XLEN-1:0] w_sel_data;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_result;
  logic            w_err;
  logic            w_wb_we;

  logic            r_valid;
  logic [XLEN-1:0] r_data;
  logic [4:0]      r_rd;
  logic            r_reg_wr;
  logic            r_err;
  logic [31:0]     r_wr_count;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_unpack
      assign w_src[gi] = src_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // An out-of-range select matches no source and yields zero.
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) w_sel_data = w_src[k];
    end
  end

  assign w_byte = w_sel_data[8*addr_lo +: 8];
  assign w_half = addr_lo[1] ? w_sel_data[31:16] : w_sel_data[15:0];

  always_comb begin
    w_result = w_sel_data;
    w_err    = 1'b0;
    if (int'(sel) == MEM_SEL) begin
      case (funct3)
        F3_LB:  w_result = {{(XLEN-8){w_byte[7]}}, w_byte};
        F3_LBU: w_result = {{(XLEN-8){1'b0}}, w_byte};
        F3_LH, F3_LHU: begin
          if (addr_lo[0]) begin
            w_result = '0;
            w_err    = 1'b1;
          end else begin
            w_result = {{(XLEN-16){w_half[15] & (funct3 == F3_LH)}}, w_half};
          end
        end
        F3_LW: begin
          if (addr_lo != 2'b00) begin
            w_result = '0;
            w_err    = 1'b1;
          end
        end
        default: begin
          w_result = '0;
          w_err    = 1'b1;
        end
      endcase
    end
  end

  assign w_wb_we = r_valid & r_reg_wr & (r_rd != 5'd0) & ~r_err;

  // Priority is flush over stall over capture; the commit counter only sees
  // an unstalled edge so a write held under stall is counted once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_rd       <= 5'd0;
      r_reg_wr   <= 1'b0;
      r_err      <= 1'b0;
      r_wr_count <= 32'd0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
        r_err   <= 1'b0;
      end else if (!stall) begin
        if (in_valid) begin
          r_valid  <= 1'b1;
          r_data   <= w_result;
          r_rd     <= rd_in;
          r_reg_wr <= reg_write;
          r_err    <= w_err;
        end else begin
          r_valid <= 1'b0;
        end
      end
      if (w_wb_we && !stall) r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign in_ready = ~stall;
  assign wb_valid = r_valid;
  assign wb_data  = r_data;
  assign wb_rd    = r_rd;
  assign wb_we    = w_wb_we;
  assign load_err = r_err;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_wb_mux_stage.sv
// Directed bench for wb_mux_stage: a behavioural model checked every cycle
// plus literal expectations for the documented scenarios.
module tb_wb_mux_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0, flush = 1'b0, reg_write = 1'b0;
  logic [1:0]  sel = 2'd0, addr_lo = 2'd0, sel3 = 2'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [4:0]  rd_in = 5'd0;
  logic [31:0] src [0:3];
  logic [127:0] src_data;
  logic [95:0]  src_data3;

  logic        in_ready, wb_valid, wb_we, load_err;
  logic [31:0] wb_data, wr_count;
  logic [4:0]  wb_rd;
  logic        in_ready3, wb_valid3, wb_we3, load_err3;
  logic [31:0] wb_data3, wr_count3;
  logic [4:0]  wb_rd3;

  int n_tests = 0;
  int n_fail  = 0;
  int preload_seq  = 0;
  int preload_seen = 0;

  assign src_data  = {src[3], src[2], src[1], src[0]};
  assign src_data3 = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  always #5 clk = ~clk;

  wb_mux_stage #(.XLEN(32), .NSRC(4), .MEM_SEL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_data(src_data), .sel(sel), .funct3(funct3), .addr_lo(addr_lo),
    .rd_in(rd_in), .reg_write(reg_write), .in_ready(in_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_we(wb_we),
    .load_err(load_err), .wr_count(wr_count)
  );

  wb_mux_stage #(.XLEN(32), .NSRC(3), .MEM_SEL(1)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_data(src_data3), .sel(sel3), .funct3(funct3), .addr_lo(addr_lo),
    .rd_in(rd_in), .reg_write(reg_write), .in_ready(in_ready3),
    .wb_valid(wb_valid3), .wb_data(wb_data3), .wb_rd(wb_rd3), .wb_we(wb_we3),
    .load_err(load_err3), .wr_count(wr_count3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference writeback value: {error, data}.
  function automatic logic [32:0] ref_wb(input int s, input logic [2:0] f3,
                                         input logic [1:0] a, input logic [31:0] w);
    logic [31:0] b, h;
    if (s >= 4) return 33'd0;
    if (s != 1) return {1'b0, w};
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000: return {1'b0, (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b};
      3'b100: return {1'b0, b};
      3'b001: return a[0] ? {1'b1, 32'd0} : {1'b0, (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h};
      3'b101: return a[0] ? {1'b1, 32'd0} : {1'b0, h};
      3'b010: return (a != 2'b00) ? {1'b1, 32'd0} : {1'b0, w};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  logic        m_valid, m_err, m_rw;
  logic [31:0] m_data, m_cnt;
  logic [4:0]  m_rd;

  function automatic bit m_we();
    return m_valid && m_rw && (m_rd != 5'd0) && !m_err;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [32:0] r;
    bit          we;
    if (rst) begin
      m_valid = 1'b0; m_err = 1'b0; m_rw = 1'b0;
      m_data = 32'd0; m_cnt = 32'd0; m_rd = 5'd0;
    end else begin
      if (preload_seq != preload_seen) begin
        m_cnt = 32'hFFFF_FFFF;
        preload_seen = preload_seq;
      end
      we = m_we();
      if (we && !stall) m_cnt = m_cnt + 32'd1;
      if (flush) begin
        m_valid = 1'b0;
        m_err   = 1'b0;
      end else if (!stall) begin
        if (in_valid) begin
          r       = ref_wb(int'(sel), funct3, addr_lo, src[sel]);
          m_valid = 1'b1;
          m_data  = r[31:0];
          m_err   = r[32];
          m_rd    = rd_in;
          m_rw    = reg_write;
        end else begin
          m_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("cmp_in_ready", {31'd0, in_ready}, {31'd0, ~stall});
      check("cmp_wb_valid", {31'd0, wb_valid}, {31'd0, m_valid});
      check("cmp_wb_data", wb_data, m_data);
      check("cmp_wb_rd", {27'd0, wb_rd}, {27'd0, m_rd});
      check("cmp_wb_we", {31'd0, wb_we}, {31'd0, m_we()});
      check("cmp_load_err", {31'd0, load_err}, {31'd0, m_err});
      check("cmp_wr_count", wr_count, m_cnt);
    end
  end

  task automatic cyc(input bit v, input bit st, input bit fl, input logic [1:0] s,
                     input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd,
                     input bit rw);
    in_valid = v; stall = st; flush = fl; sel = s;
    funct3 = f3; addr_lo = a; rd_in = rd; reg_write = rw;
    @(posedge clk);
    #1;
  endtask

  initial begin
    src[0] = 32'h1234_5678;
    src[1] = 32'h8899_AABB;
    src[2] = 32'hDEAD_BEEF;
    src[3] = 32'h0000_00F0;

    #1 rst = 1'b1;
    #1;
    check("reset_valid", {31'd0, wb_valid}, 32'd0);
    check("reset_data", wb_data, 32'd0);
    check("reset_count", wr_count, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // ALU result, then stall three cycles
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    check("alu_data", wb_data, 32'h1234_5678);
    check("alu_we", {31'd0, wb_we}, 32'd1);
    check("alu_count", wr_count, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 1, 0, 2'd2, 3'b000, 2'd0, 5'd9, 1);
      check("stall_data", wb_data, 32'h1234_5678);
      check("stall_valid", {31'd0, wb_valid}, 32'd1);
      check("stall_count", wr_count, 32'd0);
    end
    cyc(0, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    check("release_count", wr_count, 32'd1);
    check("release_valid", {31'd0, wb_valid}, 32'd0);

    // flush beats stall and capture
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    cyc(1, 1, 1, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    check("flush_valid", {31'd0, wb_valid}, 32'd0);
    check("flush_we", {31'd0, wb_we}, 32'd0);
    check("flush_count", wr_count, 32'd1);

    // load alignment and extension
    cyc(1, 0, 0, 2'd1, 3'b000, 2'd2, 5'd7, 1);
    check("lb_data", wb_data, 32'hFFFF_FF99);
    check("lb_valid", {31'd0, wb_valid}, 32'd1);
    check("lb_err", {31'd0, load_err}, 32'd0);
    cyc(1, 0, 0, 2'd1, 3'b101, 2'd0, 5'd7, 1);
    check("lhu_data", wb_data, 32'h0000_AABB);
    cyc(1, 0, 0, 2'd1, 3'b001, 2'd1, 5'd7, 1);
    check("lh_mis_data", wb_data, 32'd0);
    check("lh_mis_err", {31'd0, load_err}, 32'd1);
    check("lh_mis_we", {31'd0, wb_we}, 32'd0);
    cyc(1, 0, 0, 2'd1, 3'b100, 2'd3, 5'd7, 1);
    check("lbu_data", wb_data, 32'h0000_0088);
    cyc(1, 0, 0, 2'd1, 3'b001, 2'd2, 5'd7, 1);
    check("lh_hi_data", wb_data, 32'hFFFF_8899);
    cyc(1, 0, 0, 2'd1, 3'b010, 2'd0, 5'd7, 1);
    check("lw_data", wb_data, 32'h8899_AABB);
    cyc(1, 0, 0, 2'd1, 3'b010, 2'd2, 5'd7, 1);
    check("lw_mis_err", {31'd0, load_err}, 32'd1);
    cyc(1, 0, 0, 2'd1, 3'b011, 2'd0, 5'd7, 1);
    check("f3_011_err", {31'd0, load_err}, 32'd1);
    cyc(1, 0, 0, 2'd1, 3'b110, 2'd0, 5'd7, 1);
    check("f3_110_err", {31'd0, load_err}, 32'd1);
    cyc(1, 0, 0, 2'd2, 3'b011, 2'd1, 5'd7, 1);
    check("nonmem_data", wb_data, 32'hDEAD_BEEF);
    check("nonmem_err", {31'd0, load_err}, 32'd0);
    cyc(1, 0, 0, 2'd1, 3'b111, 2'd0, 5'd7, 1);
    cyc(0, 0, 1, 2'd0, 3'b000, 2'd0, 5'd7, 1);
    check("flush_err", {31'd0, load_err}, 32'd0);

    // rd=0 never writes; out-of-range select on the three-source build
    sel3 = 2'd3;
    cyc(1, 0, 0, 2'd3, 3'b000, 2'd0, 5'd0, 1);
    check("rd0_valid", {31'd0, wb_valid}, 32'd1);
    check("rd0_we", {31'd0, wb_we}, 32'd0);
    check("rd0_data", wb_data, 32'h0000_00F0);
    check("oor_data", wb_data3, 32'd0);
    sel3 = 2'd2;
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd0, 1);
    check("nsrc3_data", wb_data3, 32'hCAFE_0002);

    // counter wrap
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    @(negedge clk);
    #2;
    force dut.r_wr_count = 32'hFFFF_FFFF;
    preload_seq++;
    #1;
    release dut.r_wr_count;
    cyc(0, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    check("wrap_count", wr_count, 32'd0);

    // asynchronous reset between edges, held under stall and flush
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    cyc(1, 0, 0, 2'd0, 3'b000, 2'd0, 5'd5, 1);
    #2 rst = 1'b1;
    in_valid = 1'b1; stall = 1'b1; flush = 1'b1;
    #1;
    check("arst_valid", {31'd0, wb_valid}, 32'd0);
    check("arst_data", wb_data, 32'd0);
    check("arst_rd", {27'd0, wb_rd}, 32'd0);
    check("arst_count", wr_count, 32'd0);
    check("arst_we", {31'd0, wb_we}, 32'd0);
    @(posedge clk);
    #1;
    check("arst_hold_valid", {31'd0, wb_valid}, 32'd0);
    rst = 1'b0;
    cyc(1, 0, 0, 2'd1, 3'b000, 2'd2, 5'd7, 1);
    check("post_rst_data", wb_data, 32'hFFFF_FF99);
    check("post_rst_valid", {31'd0, wb_valid}, 32'd1);
    cyc(0, 0, 0, 2'd0, 3'b000, 2'd0, 5'd0, 0);
    check("post_rst_count", wr_count, 32'd1);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
